led_status_driver: RTL and testbench

- Parametrised successor to the board's free-running LED counter display.
- Drives NUM_LEDS status LEDs, each independently configurable over a simple write port.
- Modes per channel: COUNT (the legacy counter-top-bits display), STATIC, BLINK, PWM dim, and STRETCH (a retriggerable pulse stretcher for short events such as PCIe link or reset activity).
- Sits in top on the board clock; its led outputs replace the inline counter.

---
 rtl/led_status_driver.sv | 147 ++++++++++++++
 tb/tb_led_status_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_status_driver.sv
// led_status_driver: per-channel configurable LED driver.
//
// A shared free-running counter feeds every channel. Each channel holds its
// own mode, value and stretch timer, written through a one-cycle write port.
// The LED outputs are registered, so they always describe the state that
// stood before the edge (one cycle behind the counter).
//
// Channel modes:
//   COUNT   - top counter bits, reproducing the legacy counter display
//   STATIC  - value bit 0
//   BLINK   - a counter bit picked by value[4:0] (clamped to the counter MSB)
//   PWM     - cnt[PWM_BITS-1:0] < value
//   STRETCH - retriggerable pulse stretcher driven by event_in
//   5..7    - reserved, LED held off
module led_status_driver #(
    parameter int NUM_LEDS     = 8,
    parameter int CNT_WIDTH    = 32,
    parameter int PWM_BITS     = 8,
    parameter int STRETCH_BITS = 24,
    parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_wr,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [2:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_value,
    input  logic [NUM_LEDS-1:0] event_in,
    output logic [NUM_LEDS-1:0] led
);

    // Mode encodings as they appear on cfg_mode and in the mode registers.
    // Reserved encodings are stored unchanged so they read back as written.
    localparam logic [2:0] MODE_COUNT   = 3'd0;
    localparam logic [2:0] MODE_STATIC  = 3'd1;
    localparam logic [2:0] MODE_BLINK   = 3'd2;
    localparam logic [2:0] MODE_PWM     = 3'd3;
    localparam logic [2:0] MODE_STRETCH = 3'd4;

    // Highest counter bit a BLINK channel may select.
    localparam int BLINK_MAX = CNT_WIDTH - 1;

    // Value loaded by a stretch event; the LED then stays lit for
    // 2^STRETCH_BITS cycles in total (event edge plus full countdown).
    localparam logic [STRETCH_BITS-1:0] TIMER_FULL = {STRETCH_BITS{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_reg;

    // Shared free-running counter, wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
            logic                    wr_hit;
            logic                    event_take;
            logic [2:0]              mode_reg;
            logic [PWM_BITS-1:0]     value_reg;
            logic [STRETCH_BITS-1:0] timer_reg;
            logic [STRETCH_BITS-1:0] timer_next;
            logic                    led_reg;
            logic                    led_next;
            logic [4:0]              blink_k;
            logic                    blink_bit;
            logic                    count_bit;
            logic                    pwm_bit;
            logic                    stretch_bit;

            // Only in-range addresses can ever match a channel index, so
            // writes to addresses >= NUM_LEDS fall through untouched.
            assign wr_hit = cfg_wr && (cfg_addr == AW'(gi));

            // A write to this channel on the same edge drops the event.
            assign event_take = event_in[gi] && (mode_reg == MODE_STRETCH) && !wr_hit;

            // Mode and value registers, loaded by a write to this channel.
            always_ff @(posedge clk) begin
                if (reset) begin
                    mode_reg  <= MODE_COUNT;
                    value_reg <= '0;
                end else if (wr_hit) begin
                    mode_reg  <= cfg_mode;
                    value_reg <= cfg_value;
                end
            end

            // Stretch timer: write clears, accepted event reloads, otherwise
            // it runs down to zero regardless of the channel mode.
            always_comb begin
                timer_next = timer_reg;
                if (wr_hit) begin
                    timer_next = '0;
                end else if (event_take) begin
                    timer_next = TIMER_FULL;
                end else if (timer_reg != '0) begin
                    timer_next = timer_reg - STRETCH_BITS'(1);
                end
            end

            // BLINK bit selection, clamped to the counter MSB for narrow counters.
            always_comb begin
                blink_k = value_reg[4:0];
                if (int'(blink_k) > BLINK_MAX) begin
                    blink_k = BLINK_MAX[4:0];
                end
                blink_bit = |(cnt_reg & (CNT_WIDTH'(1) << blink_k));
            end

            assign count_bit   = cnt_reg[CNT_WIDTH-NUM_LEDS+gi];
            assign pwm_bit     = (cnt_reg[PWM_BITS-1:0] < value_reg);
            assign stretch_bit = (timer_reg != '0) || event_take;

            // Per-mode LED decode from the pre-edge state.
            always_comb begin
                led_next = 1'b0;
                case (mode_reg)
                    MODE_COUNT:   led_next = count_bit;
                    MODE_STATIC:  led_next = value_reg[0];
                    MODE_BLINK:   led_next = blink_bit;
                    MODE_PWM:     led_next = pwm_bit;
                    MODE_STRETCH: led_next = stretch_bit;
                    default:      led_next = 1'b0;
                endcase
            end

            // Timer state and registered LED output.
            always_ff @(posedge clk) begin
                if (reset) begin
                    timer_reg <= '0;
                    led_reg   <= 1'b0;
                end else begin
                    timer_reg <= timer_next;
                    led_reg   <= led_next;
                end
            end

            assign led[gi] = led_reg;
        end
    endgenerate

endmodule

// File: tb/tb_led_status_driver.sv
// tb_led_status_driver: directed bench for led_status_driver.
//
// A behavioural model predicts the LED vector for every edge: the counter is
// the number of edges since reset, and a stretch channel is lit when an
// accepted event lies less than 2^STRETCH_BITS edges in the past. A compare
// process checks the DUT against the model on every falling edge; literal
// expectations pin the model for the key scenarios.
module tb_led_status_driver;

    localparam int NL = 10;
    localparam int CW = 12;
    localparam int PB = 8;
    localparam int SB = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_wr;
    logic [AW-1:0] cfg_addr;
    logic [2:0]    cfg_mode;
    logic [PB-1:0] cfg_value;
    logic [NL-1:0] event_in;
    logic [NL-1:0] led;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [NL-1:0] exp_led;
    int            m_mode [NL];
    int            m_value[NL];
    bit            m_ev_valid[NL];
    longint        m_ev_edge[NL];
    longint        m_cnt  = 0;
    longint        m_edge = 0;

    led_status_driver #(
        .NUM_LEDS     (NL),
        .CNT_WIDTH    (CW),
        .PWM_BITS     (PB),
        .STRETCH_BITS (SB),
        .AW           (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_mode  (cfg_mode),
        .cfg_value (cfg_value),
        .event_in  (event_in),
        .led       (led)
    );

    always #5 clk = ~clk;

    // Predict the LED vector produced at this edge, then advance the model.
    task automatic model_edge();
        logic [NL-1:0] nl;
        bit            hit;
        bit            accept;
        bit            stretch_on;
        int            k;
        m_edge++;
        nl = '0;
        if (reset) begin
            m_cnt = 0;
            for (int i = 0; i < NL; i++) begin
                m_mode[i]     = 0;
                m_value[i]    = 0;
                m_ev_valid[i] = 1'b0;
            end
            exp_led = '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                hit        = cfg_wr && (int'(cfg_addr) == i);
                accept     = event_in[i] && (m_mode[i] == 4) && !hit;
                stretch_on = accept ||
                             (m_ev_valid[i] && ((m_edge - m_ev_edge[i]) < (64'd1 << SB)));
                k = m_value[i] % 32;
                if (k > CW - 1) k = CW - 1;
                case (m_mode[i])
                    0:       nl[i] = ((m_cnt >> (CW - NL + i)) & 1) != 0;
                    1:       nl[i] = (m_value[i] % 2) != 0;
                    2:       nl[i] = ((m_cnt >> k) & 1) != 0;
                    3:       nl[i] = (m_cnt % (64'd1 << PB)) < m_value[i];
                    4:       nl[i] = stretch_on;
                    default: nl[i] = 1'b0;
                endcase
                if (hit) begin
                    m_mode[i]     = int'(cfg_mode);
                    m_value[i]    = int'(cfg_value);
                    m_ev_valid[i] = 1'b0;
                end else if (accept) begin
                    m_ev_valid[i] = 1'b1;
                    m_ev_edge[i]  = m_edge;
                end
            end
            exp_led = nl;
            m_cnt   = (m_cnt + 1) % (64'd1 << CW);
        end
    endtask

    // Every-cycle comparison of DUT against model.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checks++;
                if (led !== exp_led) begin
                    errors++;
                    $display("FAIL model_cmp t=%0t led=%h expected=%h", $time, led, exp_led);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("check %s = %0d", name, act);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update model, settle.
    task automatic step(input bit rst, input bit wr, input int addr, input int mode,
                        input int value, input logic [NL-1:0] ev);
        reset     = rst;
        cfg_wr    = wr;
        cfg_addr  = AW'(addr);
        cfg_mode  = 3'(mode);
        cfg_value = PB'(value);
        event_in  = ev;
        if (wr) $display("write addr=%0d mode=%0d value=%0d", addr, mode, value);
        @(posedge clk);
        model_edge();
        check_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int s = 0; s < n; s++) step(1'b0, 1'b0, 0, 0, 0, '0);
    endtask

    task automatic wr(input int addr, input int mode, input int value);
        step(1'b0, 1'b1, addr, mode, value, '0);
    endtask

    // Count LED-on cycles of channel ch over n idle edges, with optional events.
    task automatic count_high(input int ch, input int n, input int ev_a, input int ev_b,
                              output int highs);
        logic [NL-1:0] ev;
        highs = 0;
        for (int s = 0; s < n; s++) begin
            ev = '0;
            if (s == ev_a || s == ev_b) ev[ch] = 1'b1;
            step(1'b0, 1'b0, 0, 0, 0, ev);
            if (led[ch] === 1'b1) highs++;
        end
    endtask

    initial begin
        int h;
        reset = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_mode = '0;
        cfg_value = '0; event_in = '0;

        step(1'b1, 1'b0, 0, 0, 0, '0);
        check_lit("reset_led", 32'(led), 0);

        // COUNT on all channels; events are ignored outside STRETCH.
        for (int s = 0; s < 9; s++) step(1'b0, 1'b0, 0, 0, 0, NL'(s * 37));
        check_lit("count_after_9", 32'(led), 2);
        idle(30);

        // STATIC on/off.
        wr(3, 1, 1);
        idle(1);
        check_lit("static_on", 32'(led[3]), 1);
        wr(3, 1, 0);
        idle(1);
        check_lit("static_off", 32'(led[3]), 0);

        // PWM duty over one full window.
        wr(0, 3, 64);
        count_high(0, 256, -1, -1, h);
        check_lit("pwm_64", h, 64);
        wr(0, 3, 0);
        count_high(0, 256, -1, -1, h);
        check_lit("pwm_0", h, 0);
        wr(0, 3, 255);
        count_high(0, 256, -1, -1, h);
        check_lit("pwm_255", h, 255);

        // BLINK: bit 3 gives half duty over 64 cycles; 31 clamps to bit 11.
        wr(1, 2, 3);
        count_high(1, 64, -1, -1, h);
        check_lit("blink_3", h, 32);
        wr(1, 2, 31);
        count_high(1, 4096, -1, -1, h);
        check_lit("blink_clamp", h, 2048);

        // STRETCH single event and retrigger.
        wr(2, 4, 0);
        count_high(2, 40, 0, -1, h);
        check_lit("stretch_single", h, 16);
        count_high(2, 40, 0, 10, h);
        check_lit("stretch_retrigger", h, 26);

        // Write and event on the same edge: event dropped.
        step(1'b0, 1'b1, 2, 4, 0, NL'(1) << 2);
        check_lit("wr_ev_same_edge", 32'(led[2]), 0);
        count_high(2, 20, -1, -1, h);
        check_lit("wr_ev_dropped", h, 0);

        // Out-of-range writes ignored; top channel reachable.
        wr(10, 1, 1);
        wr(15, 3, 200);
        idle(4);
        wr(9, 1, 1);
        idle(1);
        check_lit("addr9_static", 32'(led[9]), 1);

        // Reserved mode holds the LED off.
        wr(4, 6, 255);
        count_high(4, 32, -1, -1, h);
        check_lit("reserved_6", h, 0);

        // Reset mid-stretch and mid-PWM.
        step(1'b0, 1'b0, 0, 0, 0, NL'(1) << 2);
        idle(3);
        check_lit("stretch_active", 32'(led[2]), 1);
        step(1'b1, 1'b0, 0, 0, 0, '0);
        check_lit("reset_mid_stretch", 32'(led), 0);
        idle(20);
        wr(2, 4, 0);
        count_high(2, 20, -1, -1, h);
        check_lit("timer_cleared", h, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
